// File: rtl/keccak_pkg.sv
// Shared constants and types for the Keccak block feeder.
package keccak_pkg;
  localparam int LANE_W = 64;

  localparam logic [7:0] SHA3_SUFFIX  = 8'h06;
  localparam logic [7:0] SHAKE_SUFFIX = 8'h1F;
  localparam logic [7:0] PAD_FINAL    = 8'h80;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_ZPAD  = 2'd1,
    ST_EXTRA = 2'd2,
    ST_HOLD  = 2'd3
  } feeder_state_e;
endpackage

// File: rtl/keccak_lane_pad.sv
// Masks one lane to its valid bytes, drops the domain suffix right after them
// and optionally ORs the final pad bit into byte 7.
module keccak_lane_pad
  import keccak_pkg::*;
(
  input  logic [LANE_W-1:0] lane_in,
  input  logic [3:0]        nbytes,
  input  logic [7:0]        suffix,
  input  logic              last_lane,
  output logic [LANE_W-1:0] lane_out
);

  always_comb begin
    lane_out = '0;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < nbytes) begin
        lane_out[8*k +: 8] = lane_in[8*k +: 8];
      end else if (4'(k) == nbytes) begin
        lane_out[8*k +: 8] = suffix;
      end
    end
    if (last_lane) begin
      lane_out[LANE_W-1 -: 8] = lane_out[LANE_W-1 -: 8] | PAD_FINAL;
    end
  end

endmodule

// File: rtl/keccak_block_feeder.sv
// Packs a byte-granular lane stream into pad10*1-padded rate blocks for the
// Keccak core. Optional SHAKE suffix selection via KECCAK_FEEDER_SHAKE_EN.
//
// Handshakes: a word moves when in_valid && in_ready, a block moves when
// blk_valid && blk_ready; both ready/valid outputs decode registered state only.
module keccak_block_feeder
  import keccak_pkg::*;
#(
  parameter int RATE_LANES = 17
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [LANE_W-1:0]            in_data,
  input  logic [3:0]                   in_bytes,
  input  logic                         in_last,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [RATE_LANES*LANE_W-1:0] blk_data,
  output logic                         blk_valid,
  input  logic                         blk_ready,
  output logic                         blk_first,
  output logic                         blk_last
`ifdef KECCAK_FEEDER_SHAKE_EN
  ,
  input  logic                         shake_mode
`endif
);

  localparam int CNT_W = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATE_LANES - 1);

  feeder_state_e     state_q, state_d;
  logic [CNT_W-1:0]  lcnt_q, lcnt_d;
  logic              need_extra_q, need_extra_d;
  logic              pend_sfx_q, pend_sfx_d;
  logic              blk_first_q, blk_first_d;
  logic              blk_last_q, blk_last_d;
  logic [LANE_W-1:0] lanes_q [RATE_LANES];
  logic [LANE_W-1:0] lanes_d [RATE_LANES];

  logic [LANE_W-1:0] pad_in, pad_out;
  logic [3:0]        pad_nbytes;
  logic [7:0]        pad_suffix;
  logic              pad_last;
  logic [7:0]        suffix;
  logic              full_tail;

`ifdef KECCAK_FEEDER_SHAKE_EN
  logic shake_q, shake_d, first_word, shake_cur;
  // The mode is latched on the message's first word but must already apply to it.
  assign first_word = (state_q == ST_FILL) && blk_first_q && (lcnt_q == '0);
  assign shake_cur  = first_word ? shake_mode : shake_q;
  assign shake_d    = (first_word && in_valid) ? shake_mode : shake_q;
  assign suffix     = shake_cur ? SHAKE_SUFFIX : SHA3_SUFFIX;
`else
  assign suffix = SHA3_SUFFIX;
`endif

  // A full final lane in the last slot leaves no room for padding.
  assign full_tail = (in_bytes >= 4'd8) && (lcnt_q == LAST_IDX);

  keccak_lane_pad u_lane_pad (
    .lane_in   (pad_in),
    .nbytes    (pad_nbytes),
    .suffix    (pad_suffix),
    .last_lane (pad_last),
    .lane_out  (pad_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_FILL;
      lcnt_q       <= '0;
      need_extra_q <= 1'b0;
      pend_sfx_q   <= 1'b0;
      blk_first_q  <= 1'b1;
      blk_last_q   <= 1'b0;
      lanes_q      <= '{default: '0};
`ifdef KECCAK_FEEDER_SHAKE_EN
      shake_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      lcnt_q       <= lcnt_d;
      need_extra_q <= need_extra_d;
      pend_sfx_q   <= pend_sfx_d;
      blk_first_q  <= blk_first_d;
      blk_last_q   <= blk_last_d;
      lanes_q      <= lanes_d;
`ifdef KECCAK_FEEDER_SHAKE_EN
      shake_q      <= shake_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FILL: begin
        if (in_valid) begin
          if (lcnt_q == LAST_IDX) state_d = ST_HOLD;
          else if (in_last)       state_d = ST_ZPAD;
        end
      end
      ST_ZPAD:  state_d = ST_HOLD;
      ST_EXTRA: state_d = ST_HOLD;
      ST_HOLD: begin
        if (blk_ready) state_d = need_extra_q ? ST_EXTRA : ST_FILL;
      end
      default:  state_d = ST_FILL;
    endcase
  end

  always_comb begin
    pad_in     = '0;
    pad_nbytes = 4'd8;
    pad_suffix = '0;
    pad_last   = 1'b0;
    unique case (state_q)
      ST_FILL: begin
        pad_in     = in_data;
        pad_nbytes = in_last ? in_bytes : 4'd8;
        pad_suffix = suffix;
        pad_last   = in_last && (lcnt_q == LAST_IDX) && !full_tail;
      end
      ST_ZPAD: begin
        // Suffix is pending here only when the tail lane was completely full.
        pad_nbytes = 4'd0;
        pad_suffix = pend_sfx_q ? suffix : 8'h00;
        pad_last   = (lcnt_q == LAST_IDX);
      end
      ST_EXTRA: begin
        pad_nbytes = 4'd0;
        pad_suffix = suffix;
      end
      default: begin
        pad_nbytes = 4'd8;
      end
    endcase
  end

  always_comb begin
    lanes_d      = lanes_q;
    lcnt_d       = lcnt_q;
    need_extra_d = need_extra_q;
    pend_sfx_d   = pend_sfx_q;
    blk_first_d  = blk_first_q;
    blk_last_d   = blk_last_q;
    unique case (state_q)
      ST_FILL: begin
        if (in_valid) begin
          lanes_d[lcnt_q] = pad_out;
          if (lcnt_q != LAST_IDX) lcnt_d = lcnt_q + CNT_W'(1);
          if (in_last) begin
            blk_last_d = !full_tail;
            if (full_tail)                need_extra_d = 1'b1;
            else if (in_bytes >= 4'd8)    pend_sfx_d   = 1'b1;
          end
        end
      end
      ST_ZPAD: begin
        lanes_d[lcnt_q] = pad_out;
        lanes_d[RATE_LANES-1][LANE_W-1 -: 8] = lanes_d[RATE_LANES-1][LANE_W-1 -: 8] | PAD_FINAL;
        pend_sfx_d = 1'b0;
      end
      ST_EXTRA: begin
        lanes_d[0] = pad_out;
        lanes_d[RATE_LANES-1][LANE_W-1 -: 8] = lanes_d[RATE_LANES-1][LANE_W-1 -: 8] | PAD_FINAL;
        need_extra_d = 1'b0;
        blk_last_d   = 1'b1;
      end
      ST_HOLD: begin
        if (blk_ready) begin
          lanes_d     = '{default: '0};
          lcnt_d      = '0;
          blk_first_d = blk_last_q;
          blk_last_d  = 1'b0;
        end
      end
      default: begin
        lcnt_d = '0;
      end
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_FILL);
    blk_valid = (state_q == ST_HOLD);
    blk_first = blk_first_q;
    blk_last  = blk_last_q;
  end

  for (genvar i = 0; i < RATE_LANES; i++) begin : g_lane
    assign blk_data[i*LANE_W +: LANE_W] = lanes_q[i];
  end

endmodule

// File: doc/keccak_block_feeder.md
# keccak_block_feeder

Assembles a byte-granular message stream, delivered as 64-bit lanes, into rate-sized Keccak blocks. Applies SHA-3 pad10*1 with a domain suffix, and presents each completed block to the permutation core's controller with first/last qualifiers. It is the producer side of the core's block-load interface: it drives the block data together with `first_block` and `flag`, and the controller's `load` pulse consumes each block.

## Interface
- `RATE_LANES`, 17: lanes per block; rate in bytes is R = 8·RATE_LANES (17 gives 136 B, SHA3-256).
- `LANE_W`, 64: lane width in bits; fixed by the Keccak-f[1600] core.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_data` in 64: message lane, little-endian; byte k occupies bits [8k+7:8k].
- `in_bytes` in 4: valid bytes in `in_data`, 0..8. Must be 8 unless `in_last`=1. A value of 0 is legal only with `in_last`, for an empty tail or empty message.
- `in_last` in 1: final lane of the message.
- `in_valid` in 1: input word present.
- `in_ready` out 1: feeder accepts a word this cycle.
- `blk_data` out RATE_LANES·64: padded block; lane i occupies bits [64i+63:64i].
- `blk_valid` out 1: block held and stable.
- `blk_ready` in 1: core takes the block; driven from the controller's `load`.
- `blk_first` out 1: block is the first of its message; maps to the core's `first_block`.
- `blk_last` out 1: block is the final block; maps to the core's `flag`.

## Operation
- Input handshake: a word transfers when `in_valid && in_ready`. Output handshake: a block transfers when `blk_valid && blk_ready`.
- The FSM has states FILL, ZPAD, EXTRA and HOLD.
- **FILL** (`in_ready`=1):
  - Each accepted word is written to lane `lcnt`, then `lcnt` increments.
  - A word at `lcnt`=RATE_LANES−1 that is not last goes to HOLD with `blk_last`=0.
  - On `in_last`, byte position p = 8·lcnt + in_bytes. Bytes at p and above in that lane are cleared, and byte p gets `SUFFIX` (0x06).
    - If p < R, byte R−1 gets |=0x80 in the same block; p = R−1 yields 0x86. Go to ZPAD if lanes remain, otherwise HOLD, with `blk_last`=1.
    - If p = R (full final lane at the last lane index), go to HOLD with `blk_last`=0 and set `need_extra`.
- **ZPAD**: writes zero to one lane per cycle until lane RATE_LANES−1, ORing 0x80 into byte 7 of the last lane, then goes to HOLD.
  - Lanes 0..lcnt−1 keep their data.
  - ZPAD may instead clear all remaining lanes in one cycle; either way the observable block is identical.
- **EXTRA**: builds a padding-only block: byte 0 = SUFFIX, byte R−1 = 0x80, all others 0. Goes to HOLD with `blk_last`=1.
- **HOLD** (`in_ready`=0, `blk_valid`=1):
  - On `blk_ready`: clears `lcnt`.
  - Next state is EXTRA if `need_extra`, otherwise FILL.
  - `blk_first` clears after any accepted block and sets again after a `blk_last` block is accepted.
- `blk_data`, `blk_first` and `blk_last` are stable for the whole time `blk_valid` is high.
- `blk_ready` while `blk_valid`=0 is ignored.
- Lane storage is cleared to zero when a block is accepted, so stale data never leaks into a partial block.

## Timing
- Reset values after the reset edge:
  - Outputs: `in_ready`=1, `blk_valid`=0, `blk_first`=1, `blk_last`=0, `blk_data`=0.
  - Internal: `lcnt`=0, `need_extra`=0, state FILL.
- Reset mid-block or mid-HOLD discards all partial and held data.
- Throughput is one lane per cycle in FILL.
- `blk_valid` rises the cycle after the final lane is written, or after the ZPAD/EXTRA cycle.
- Minimum gap after an accepted block: 1 cycle before `in_ready` is high again. The EXTRA block becomes valid 2 cycles after the preceding block is accepted.
- `in_ready` is a registered-state decode only. It is never combinational on `blk_ready`.

## Configuration
- `KECCAK_FEEDER_SHAKE_EN` defined:
  - Adds input `shake_mode` (1 bit), sampled on the first accepted word of each message and held until that message's last block is accepted.
  - SUFFIX = 0x1F when `shake_mode`=1, 0x06 otherwise.
- Undefined: no port; SUFFIX is the constant 0x06.

## Structure
- Shared package `keccak_pkg` holds:
  - `LANE_W`.
  - `SHA3_SUFFIX` = 8'h06 and `SHAKE_SUFFIX` = 8'h1F.
  - `PAD_FINAL` = 8'h80.
  - The feeder state enum.
- Sub-module `keccak_lane_pad`: combinational function of lane data, `in_bytes`, suffix and a last-lane flag, producing the masked and padded lane. It is used by FILL, ZPAD and EXTRA.

## Test plan
- Empty message (`in_bytes`=0, `in_last`=1, lcnt 0) → one block: byte0=0x06, byte135=0x80, all others 0; `blk_first`=1, `blk_last`=1.
- 3-byte "abc" (`in_data`=0x636261, `in_bytes`=3, last) → lane0=0x0000_0000_0663_6261, lane16=0x8000_0000_0000_0000; first=1, last=1.
- 17 full lanes with the last flagged at lane 16 → block 1: first=1, last=0. Block 2: padding-only with byte0=0x06 and byte135=0x80; first=0, last=1.
- Final lane at lane 16 with `in_bytes`=7 → byte135=0x86, single block, last=1.
- Hold `blk_ready`=0 for 10 cycles while `in_valid`=1 → `in_ready`=0 and `blk_data` unchanged. Then pulse `blk_ready` → `in_ready`=1 one cycle later.
- Assert `rst` mid-FILL after 5 lanes, then send "abc" → output identical to the "abc" scenario, with no stale lanes.
